serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand and result width in bits (legal range 1..32).
REQ-002 SHALL have port: clk  input  1  single clock, all state changes on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand set a/b/cin offered.
REQ-005 SHALL have port: in_ready  output  1  block accepts operands this cycle.
REQ-006 SHALL have port: a  input  WIDTH  first operand.
REQ-007 SHALL have port: b  input  WIDTH  second operand.
REQ-008 SHALL have port: cin  input  1  carry-in of the whole addition.
REQ-009 SHALL have port: out_valid  output  1  result/cout hold a completed sum.
REQ-010 SHALL have port: out_ready  input  1  consumer takes the result this cycle.
REQ-011 SHALL have port: result  output  WIDTH  sum bits.
REQ-012 SHALL have port: cout  output  1  final carry-out.

Function
REQ-013 SHALL implement a three-state FSM with states IDLE, ADD and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 SHALL, in IDLE on in_valid&&in_ready at an edge, capture a and b into shift registers, cin into the carry register, clear the bit counter, and enter ADD.
REQ-016 SHALL, in each ADD cycle, feed operand-register LSBs plus the carry register to one full-adder, shift the sum bit into result from the MSB side (result shifts right), update the carry register from the adder carry-out, shift operand registers right, and increment the counter.
REQ-017 SHALL leave ADD for DONE on the edge where counter==WIDTH-1, making out_valid high exactly WIDTH edges after the acceptance edge; WIDTH=1 gives one ADD cycle.
REQ-018 SHALL drive cout from the carry register; {cout,result} SHALL equal a+b+cin computed in WIDTH+1 bits.
REQ-019 SHALL hold DONE, with result and cout stable, while out_ready=0 (unbounded backpressure).
REQ-020 SHALL return to IDLE on the edge where out_valid&&out_ready; out_ready already high on DONE entry gives a one-cycle out_valid pulse.
REQ-021 SHALL ignore in_valid and any change on a, b, cin during ADD and DONE; no operand is queued.
REQ-022 SHALL make result and cout meaningful only while out_valid=1; intermediate values during ADD carry no contract.
REQ-023 SHALL sustain one transaction per WIDTH+2 cycles at best (accept, WIDTH ADD cycles, DONE handoff).

Reset
REQ-024 SHALL, on rst_n low, immediately and asynchronously force state=IDLE, in_ready=1, out_valid=0, result=0, cout=0, counter=0, operand and carry registers=0.
REQ-025 SHALL, on reset mid-ADD or mid-DONE, abandon the transaction with no out_valid pulse; the next accepted operands compute correctly.

Structure
REQ-026 SHALL place the state enum type (IDLE/ADD/DONE) and the default WIDTH constant in a shared package, serial_adder_pkg.
REQ-027 SHALL instantiate the existing one-bit fulladder (ports a, b, cin, result, cout) as its sole sub-module for the per-bit add; no '+' operator on operand data.
REQ-028 SHALL size the counter as $clog2(WIDTH) bits, minimum 1.

Verification (WIDTH=8)
REQ-029 SHALL check reset: rst_n=0 -> in_ready=1, out_valid=0, result=0x00, cout=0 without a clock edge.
REQ-030 SHALL check a=0x00,b=0x00,cin=0 -> out_valid 8 edges after acceptance, result=0x00, cout=0.
REQ-031 SHALL check full ripple: a=0xFF,b=0x01,cin=0 -> result=0x00, cout=1; and a=0xFF,b=0xFF,cin=1 -> result=0xFF, cout=1.
REQ-032 SHALL check backpressure: out_ready=0 for 5 cycles after a=0x12,b=0x34,cin=0 -> result=0x46 stable, in_ready=0, a second in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-033 SHALL check reset on ADD cycle 3 -> out_valid never asserts, in_ready=1 at once; then a=0x5A,b=0x33,cin=0 -> result=0x8D, cout=0.
REQ-034 SHALL check back-to-back with out_ready tied high: 0x80+0x80+0 -> result=0x00, cout=1; next 0x01+0x02+1 -> result=0x04, cout=0; each out_valid exactly one cycle wide.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the controller state encoding, the default operand width and the counter sizing rule.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // A one-bit design still needs a one-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/fulladder.sv
// One-bit full adder used as the per-bit arithmetic core of the serial adder.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic result,
    output logic cout
);

    assign result = a ^ b ^ cin;
    assign cout   = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts a/b/cin, adds one bit per cycle through a single full adder,
// then presents {cout,result} until the consumer takes it.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q,  carry_d;
    logic [CW-1:0]    cnt_q,    cnt_d;

    logic sum_bit;
    logic carry_bit;

    fulladder u_fulladder (
        .a      (a_q[0]),
        .b      (b_q[0]),
        .cin    (carry_q),
        .result (sum_bit),
        .cout   (carry_bit)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                // Sum bits enter at the MSB so after WIDTH shifts bit 0 holds the first sum.
                result_d = (result_q >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));
                carry_d  = carry_bit;
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign cout      = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed corner cases plus randomized
// transactions compared against an arithmetic reference model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;

    int checks;
    int errors;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the whole sum as plain (W+1)-bit arithmetic.
    function automatic logic [W:0] refSum(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Offer one operand set on a falling edge; returns on the falling edge after acceptance.
    task automatic applyStimulus(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        @(negedge clk);
        a        = ta;
        b        = tb;
        cin      = tc;
        in_valid = 1'b1;
        checkOutput("in_ready_idle", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait for out_valid while scribbling on the inputs; the DUT must ignore them.
    task automatic waitDone(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            in_valid = (lat < 4);
            a        = W'($urandom);
            b        = W'($urandom);
            cin      = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        checkOutput("latency", lat, W);
    endtask

    // Full transaction: accept, wait, check sum, hold for `stall` cycles, release.
    task automatic runTxn(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input int stall);
        logic [W:0] expSum;
        int lat;
        expSum    = refSum(ta, tb, tc);
        out_ready = (stall == 0);
        applyStimulus(ta, tb, tc);
        waitDone(lat);
        checkOutput("result", {24'd0, result}, {24'd0, expSum[W-1:0]});
        checkOutput("cout", {31'd0, cout}, {31'd0, expSum[W]});
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("hold_result", {24'd0, result}, {24'd0, expSum[W-1:0]});
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("pulse_end", {31'd0, out_valid}, 32'd0);
        checkOutput("back_idle", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [W:0] expSum;
        int lat;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;

        #1;
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_result", {24'd0, result}, 32'd0);
        checkOutput("rst_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed sums");
        runTxn(8'h00, 8'h00, 1'b0, 0);
        runTxn(8'hFF, 8'h01, 1'b0, 0);
        runTxn(8'hFF, 8'hFF, 1'b1, 0);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(8'h12, 8'h34, 1'b0);
        waitDone(lat);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = 8'hAA;
            b        = 8'h55;
            @(negedge clk);
            checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("bp_result", {24'd0, result}, 32'h46);
            checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_idle", {31'd0, in_ready}, 32'd1);
        checkOutput("bp_release_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("no_queued_op", {31'd0, out_valid}, 32'd0);
        end

        $display("[TB] reset while holding a result");
        out_ready = 1'b0;
        applyStimulus(8'hC3, 8'h7E, 1'b1);
        waitDone(lat);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstdone_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rstdone_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rstdone_result", {24'd0, result}, 32'd0);
        checkOutput("rstdone_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] reset during ADD");
        out_ready = 1'b1;
        applyStimulus(8'hF0, 8'h0F, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstadd_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rstadd_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("rstadd_no_valid", {31'd0, out_valid}, 32'd0);
        end
        runTxn(8'h5A, 8'h33, 1'b0, 0);

        $display("[TB] back-to-back");
        runTxn(8'h80, 8'h80, 1'b0, 0);
        runTxn(8'h01, 8'h02, 1'b1, 0);

        $display("[TB] randomized");
        for (int n = 0; n < 30; n++) begin
            runTxn(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        expSum = refSum(8'hFF, 8'hFF, 1'b1);
        checkOutput("model_sanity", {23'd0, expSum}, 32'h1FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
